// File: rtl/counter_read_collector.sv
// -----------------------------------------------------------------------------
// counter_read_collector
//
// Read-side front end for the shared counters array. A request names a base
// counter id. The block then drives the array's READ command and that id,
// collects the G-bit beats that the array streams back, packs them into one
// N*G-bit value and returns it on a valid/ready response port. Only one read
// is in flight at any time.
//
// Ports
//   clk        in   clock, all state updates on the rising edge
//   rst        in   synchronous, active-low reset
//   req_valid  in   read request valid
//   req_ready  out  request accepted when req_valid && req_ready (IDLE only)
//   req_id     in   counter id (base subcounter index) to read
//   cmd_out    out  array command: 3'b101 while reading, else 3'b000
//   cmd_id     out  array id: latched id while reading, else 0
//   sc_rdata   in   beat data from the array
//   sc_rvalid  in   beat valid from the array
//   sc_last    in   last-beat flag from the array, meaningful with sc_rvalid
//   rsp_valid  out  response valid
//   rsp_ready  in   response consumed when rsp_valid && rsp_ready
//   rsp_value  out  packed value, beat k at [k*G +: G], unused bits 0
//   rsp_beats  out  number of beats captured
//   rsp_err    out  timeout, missing last, or id out of range
// -----------------------------------------------------------------------------
module counter_read_collector #(
  parameter int N       = 10,
  parameter int G       = 4,
  parameter int TIMEOUT = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [$clog2(N)-1:0]   req_id,
  output logic [2:0]             cmd_out,
  output logic [$clog2(N)-1:0]   cmd_id,
  input  logic [G-1:0]           sc_rdata,
  input  logic                   sc_rvalid,
  input  logic                   sc_last,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [N*G-1:0]         rsp_value,
  output logic [$clog2(N):0]     rsp_beats,
  output logic                   rsp_err
);

  localparam int IDW = $clog2(N);
  localparam int BW  = $clog2(N) + 1;
  localparam int VW  = N * G;
  localparam int TW  = $clog2(TIMEOUT + 1);

  localparam logic [BW-1:0] N_BW        = BW'(N);
  localparam logic [TW-1:0] TIMEOUT_TW  = TW'(TIMEOUT);
  localparam logic [2:0]    CMD_READ    = 3'b101;
  localparam logic [2:0]    CMD_NOP     = 3'b000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t          state_r, state_s;
  logic [IDW-1:0]  id_r, id_s;
  logic [VW-1:0]   acc_r, acc_s;
  logic [BW-1:0]   beats_r, beats_s;
  logic [TW-1:0]   tmo_r, tmo_s;
  logic [VW-1:0]   val_r, val_s;
  logic [BW-1:0]   rbeats_r, rbeats_s;
  logic            err_r, err_s;

  // Helpers derived from the current beat / id.
  logic [VW-1:0]   beat_acc_s;
  logic [BW-1:0]   beats_inc_s;
  logic [BW-1:0]   remaining_s;
  logic [TW-1:0]   tmo_inc_s;
  logic            id_in_range_s;

  // Accumulator with the incoming beat merged at slot beats_r; slots >= N never written.
  always_comb begin
    beat_acc_s = acc_r;
    for (int k = 0; k < N; k++) begin
      if (beats_r == BW'(k)) begin
        beat_acc_s[k*G +: G] = sc_rdata;
      end else begin
        beat_acc_s[k*G +: G] = acc_r[k*G +: G];
      end
    end
  end

  // Counter increments and the number of subcounters left above the base id.
  always_comb begin
    beats_inc_s   = beats_r + BW'(1);
    tmo_inc_s     = tmo_r + TW'(1);
    // The top subcounter never raises last, so the read also ends after N-id beats.
    remaining_s   = N_BW - {1'b0, id_r};
    id_in_range_s = ({1'b0, req_id} < N_BW);
  end

  // Next-state and next-register logic for the IDLE/READ/RESP controller.
  always_comb begin
    state_s  = state_r;
    id_s     = id_r;
    acc_s    = acc_r;
    beats_s  = beats_r;
    tmo_s    = tmo_r;
    val_s    = val_r;
    rbeats_s = rbeats_r;
    err_s    = err_r;

    case (state_r)
      ST_IDLE: begin
        if (req_valid) begin
          if (id_in_range_s) begin
            id_s    = req_id;
            acc_s   = {VW{1'b0}};
            beats_s = {BW{1'b0}};
            tmo_s   = {TW{1'b0}};
            state_s = ST_READ;
          end else begin
            // Out-of-range id: answer immediately, never touch the array.
            val_s    = {VW{1'b0}};
            rbeats_s = {BW{1'b0}};
            err_s    = 1'b1;
            state_s  = ST_RESP;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_READ: begin
        if (sc_rvalid) begin
          acc_s   = beat_acc_s;
          beats_s = beats_inc_s;
          if (sc_last || (beats_inc_s == remaining_s)) begin
            val_s    = beat_acc_s;
            rbeats_s = beats_inc_s;
            err_s    = 1'b0;
            state_s  = ST_RESP;
          end else begin
            state_s = ST_READ;
          end
        end else if (beats_r != {BW{1'b0}}) begin
          // Stream stopped before last: report what was captured, flagged bad.
          val_s    = acc_r;
          rbeats_s = beats_r;
          err_s    = 1'b1;
          state_s  = ST_RESP;
        end else if (tmo_inc_s == TIMEOUT_TW) begin
          val_s    = {VW{1'b0}};
          rbeats_s = {BW{1'b0}};
          err_s    = 1'b1;
          state_s  = ST_RESP;
        end else begin
          tmo_s   = tmo_inc_s;
          state_s = ST_READ;
        end
      end

      ST_RESP: begin
        // Stray beats arriving here are ignored; NOP command lets the array rearm.
        if (rsp_ready) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_RESP;
        end
      end

      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r  <= ST_IDLE;
      id_r     <= {IDW{1'b0}};
      acc_r    <= {VW{1'b0}};
      beats_r  <= {BW{1'b0}};
      tmo_r    <= {TW{1'b0}};
      val_r    <= {VW{1'b0}};
      rbeats_r <= {BW{1'b0}};
      err_r    <= 1'b0;
    end else begin
      state_r  <= state_s;
      id_r     <= id_s;
      acc_r    <= acc_s;
      beats_r  <= beats_s;
      tmo_r    <= tmo_s;
      val_r    <= val_s;
      rbeats_r <= rbeats_s;
      err_r    <= err_s;
    end
  end

  // Command, handshake and response-valid decode from the registered state.
  always_comb begin
    cmd_out   = CMD_NOP;
    cmd_id    = {IDW{1'b0}};
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state_r)
      ST_IDLE: begin
        req_ready = 1'b1;
      end
      ST_READ: begin
        cmd_out = CMD_READ;
        cmd_id  = id_r;
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
      end
      default: begin
        req_ready = 1'b0;
      end
    endcase
  end

  assign rsp_value = val_r;
  assign rsp_beats = rbeats_r;
  assign rsp_err   = err_r;

endmodule
